mc_control_fsm: RTL
===================

Name: mc_control_fsm

Overview:
Multi-cycle control unit for the MIPS core; successor to the single-cycle opcode decoder.
- Sequences every instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states, sharing one ALU and one unified memory port.
- Memory accesses take a parametrised number of cycles.
- Every output is fully defined in every state (Moore, registered state), and illegal opcodes are flagged.
- Sits between the instruction register opcode field and the multi-cycle datapath muxes and enables.

Parameters:
- OPCODE_W, 6: opcode field width.
- MEM_LAT, 1: cycles each memory access occupies (legal range 1..15).
- CNT_W, 4: wait-counter width; must satisfy 2^CNT_W > MEM_LAT.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- opcode, input, OPCODE_W: IR[31:26], valid from DECODE onward.
- pc_write, output, 1: unconditional PC load.
- branch_eq, output, 1: PC load if ALU zero.
- branch_ne, output, 1: PC load if not ALU zero.
- iord, output, 1: memory address select; 0=PC, 1=ALUOut.
- mem_read, output, 1: memory read strobe.
- mem_write, output, 1: memory write strobe.
- ir_write, output, 1: IR load enable.
- mem_to_reg, output, 1: writeback data select; 1=MDR.
- reg_dst, output, 1: destination select; 1=rd, 0=rt.
- reg_write, output, 1: register file write enable.
- alu_src_a, output, 1: ALU A select; 0=PC, 1=regA.
- alu_src_b, output, 2: ALU B select; 00=regB, 01=4, 10=sext imm, 11=sext imm<<2.
- alu_op, output, 2: 00=add, 01=sub, 10=funct, 11=slt.
- pc_source, output, 2: 00=ALU result, 01=ALUOut, 10=jump target.
- illegal_op, output, 1: one-cycle pulse on unsupported opcode.
- instr_done, output, 1: one-cycle pulse on the last cycle of each instruction.
- state_o, output, 4: current state encoding, for debug.

Behaviour:
- Reset: state=FETCH, wait_cnt=0, all outputs 0 (the FETCH Moore outputs start on the first cycle after reset deassertion). Reset asserted mid-instruction aborts it immediately; no write strobe is asserted in the cycle after reset.
- States (encoding):
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, RWB=7, EXEC_I=8, IWB=9, BRANCH=10, JUMP=11.
- Defaults: every output is 0 unless listed for the current state.
- FETCH:
  - All cycles: mem_read=1, iord=0.
  - Stays MEM_LAT cycles, counted by wait_cnt.
  - Final cycle only: ir_write=1, pc_write=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - Then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
  - 100011 lw, 101011 sw -> MEMADR.
  - 000000 R-type -> EXEC_R.
  - 001000 addi, 001010 slti -> EXEC_I.
  - 000100 beq, 000101 bne -> BRANCH.
  - 000010 j -> JUMP.
  - Any other opcode: illegal_op=1 and instr_done=1 this cycle, then FETCH. No register or memory write occurs.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEMRD; sw -> MEMWR.
- MEMRD: mem_read=1, iord=1 for MEM_LAT cycles, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1; then FETCH.
- MEMWR: mem_write=1, iord=1 for MEM_LAT cycles; instr_done=1 on the final cycle; then FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; then RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1; then FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00 for addi, 11 for slti; then IWB.
- IWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1; then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, instr_done=1. branch_eq=1 for beq, branch_ne=1 for bne, never both. Then FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1; then FETCH.
- Wait counter:
  - Cleared on entry to FETCH, MEMRD and MEMWR.
  - Increments each cycle in those states.
  - Exit when wait_cnt==MEM_LAT-1.
  - With MEM_LAT=1 each memory state lasts exactly one cycle. The counter never wraps.
- Latency in cycles, L=MEM_LAT:
  - lw: 2L+3.
  - sw: 2L+2.
  - R-type, addi, slti: L+3.
  - beq, bne, j: L+2.
  - illegal: L+1.
- Opcode is sampled in DECODE and in every later state; the datapath holds IR stable until the next FETCH final cycle.
- The unused encodings 12-15 are unreachable; if entered, the FSM goes to FETCH on the next cycle with all outputs 0.

Test Plan:
- Reset, MEM_LAT=1: hold reset 2 cycles, release -> state_o=0, all outputs 0 while in reset. First cycle after release: mem_read=1, ir_write=1, pc_write=1.
- MEM_LAT=1, opcode=000000 -> states 0,1,6,7. reg_write=1 and reg_dst=1 only in state 7. instr_done on cycle 4.
- MEM_LAT=3, opcode=100011 -> FETCH 3 cycles (ir_write only on the 3rd), then 1,2, MEMRD 3 cycles with iord=1, then MEMWB. Total 9 cycles, with mem_to_reg=1 and reg_write=1 in the last.
- MEM_LAT=2, opcodes 000101 then 000100 -> BRANCH asserts branch_ne=1/branch_eq=0, then branch_eq=1/branch_ne=0. pc_source=01, alu_op=01, 4 cycles each.
- Opcode=111111 -> illegal_op=1 and instr_done=1 in DECODE, next state 0. No reg_write or mem_write at any point.
- Assert reset during MEMWR with MEM_LAT=4 -> mem_write=0 on the next cycle, state_o=0, wait_cnt restarts from 0.

Source files
------------

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_fsm
// Brief    : Multi-cycle MIPS control unit. Moore outputs decoded from the
//            registered state, with a wait counter for multi-cycle memory.
// Revision : 1.0 - initial release
// ============================================================================
module mc_control_fsm #(
    parameter int OPCODE_W = 6,
    parameter int MEM_LAT  = 1,
    parameter int CNT_W    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                pc_write,
    output logic                branch_eq,
    output logic                branch_ne,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_source,
    output logic                illegal_op,
    output logic                instr_done,
    output logic [3:0]          state_o
);

    localparam logic [3:0] c_st_fetch  = 4'd0;
    localparam logic [3:0] c_st_decode = 4'd1;
    localparam logic [3:0] c_st_memadr = 4'd2;
    localparam logic [3:0] c_st_memrd  = 4'd3;
    localparam logic [3:0] c_st_memwb  = 4'd4;
    localparam logic [3:0] c_st_memwr  = 4'd5;
    localparam logic [3:0] c_st_exec_r = 4'd6;
    localparam logic [3:0] c_st_rwb    = 4'd7;
    localparam logic [3:0] c_st_exec_i = 4'd8;
    localparam logic [3:0] c_st_iwb    = 4'd9;
    localparam logic [3:0] c_st_branch = 4'd10;
    localparam logic [3:0] c_st_jump   = 4'd11;

    localparam logic [OPCODE_W-1:0] c_op_rtype = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] c_op_j     = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] c_op_beq   = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] c_op_bne   = OPCODE_W'(6'b000101);
    localparam logic [OPCODE_W-1:0] c_op_addi  = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] c_op_slti  = OPCODE_W'(6'b001010);
    localparam logic [OPCODE_W-1:0] c_op_lw    = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] c_op_sw    = OPCODE_W'(6'b101011);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(MEM_LAT - 1);

    logic [3:0]       r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [3:0]       w_next_state;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_wait_done;
    logic             w_op_legal;

    assign w_wait_done = (r_wait_cnt == c_cnt_last);

    assign w_op_legal = (opcode == c_op_rtype) || (opcode == c_op_j)
                     || (opcode == c_op_beq)   || (opcode == c_op_bne)
                     || (opcode == c_op_addi)  || (opcode == c_op_slti)
                     || (opcode == c_op_lw)    || (opcode == c_op_sw);

    always_comb begin
        w_next_state = c_st_fetch;
        case (r_state)
            c_st_fetch:  w_next_state = w_wait_done ? c_st_decode : c_st_fetch;
            c_st_decode: begin
                if (opcode == c_op_lw || opcode == c_op_sw)
                    w_next_state = c_st_memadr;
                else if (opcode == c_op_rtype)
                    w_next_state = c_st_exec_r;
                else if (opcode == c_op_addi || opcode == c_op_slti)
                    w_next_state = c_st_exec_i;
                else if (opcode == c_op_beq || opcode == c_op_bne)
                    w_next_state = c_st_branch;
                else if (opcode == c_op_j)
                    w_next_state = c_st_jump;
                else
                    w_next_state = c_st_fetch;
            end
            c_st_memadr: w_next_state = (opcode == c_op_lw) ? c_st_memrd : c_st_memwr;
            c_st_memrd:  w_next_state = w_wait_done ? c_st_memwb : c_st_memrd;
            c_st_memwr:  w_next_state = w_wait_done ? c_st_fetch : c_st_memwr;
            c_st_exec_r: w_next_state = c_st_rwb;
            c_st_exec_i: w_next_state = c_st_iwb;
            default:     w_next_state = c_st_fetch;
        endcase
    end

    // Only the three wait states ever self-loop, so any state change restarts the count.
    assign w_next_cnt = (w_next_state == r_state) ? (r_wait_cnt + CNT_W'(1)) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_st_fetch;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_cnt;
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        branch_eq  = 1'b0;
        branch_ne  = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_source  = 2'b00;
        illegal_op = 1'b0;
        instr_done = 1'b0;
        state_o    = 4'd0;
        // Outputs are forced quiet while reset is held so an aborted write never leaks.
        if (!reset) begin
            state_o = r_state;
            case (r_state)
                c_st_fetch: begin
                    mem_read = 1'b1;
                    if (w_wait_done) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        alu_src_b = 2'b01;
                    end
                end
                c_st_decode: begin
                    alu_src_b = 2'b11;
                    if (!w_op_legal) begin
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                c_st_memadr: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                c_st_memrd: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                c_st_memwb: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                c_st_memwr: begin
                    mem_write  = 1'b1;
                    iord       = 1'b1;
                    instr_done = w_wait_done;
                end
                c_st_exec_r: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                c_st_rwb: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                end
                c_st_exec_i: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = (opcode == c_op_slti) ? 2'b11 : 2'b00;
                end
                c_st_iwb: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                c_st_branch: begin
                    alu_src_a  = 1'b1;
                    alu_op     = 2'b01;
                    pc_source  = 2'b01;
                    instr_done = 1'b1;
                    branch_eq  = (opcode == c_op_beq);
                    branch_ne  = (opcode == c_op_bne);
                end
                c_st_jump: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    instr_done = 1'b1;
                end
                default: begin
                    state_o = r_state;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
